memory_stage: RTL and testbench

Memory-access stage of the five-stage Y86-64 pipeline. It consumes the M pipeline register outputs, performs at most one 64-bit data-memory transaction per instruction over a req/ack bus, and produces `m_valM_o`/`m_stat_o` for the M→W register and forwarding. While a transaction is outstanding it raises `m_busy_o`, which pipeline control uses to stall M and bubble W.

---
 rtl/memory_stage.sv | 168 ++++++++++++++++
 tb/tb_memory_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Y86-64 memory-access stage: one 64-bit data-memory transaction per instruction
// over a req/ack bus, with stall request, bus-error and timeout handling.
module memory_stage #(
    parameter int MEM_BYTES = 65536,
    parameter int TIMEOUT   = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [2:0]  M_stat_i,
    input  logic [3:0]  M_icode_i,
    input  logic [63:0] M_valE_i,
    input  logic [63:0] M_valA_i,
    input  logic        W_stall_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [63:0] dmem_addr_o,
    output logic [63:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [63:0] dmem_rdata_i,
    input  logic        dmem_err_i,
    output logic [63:0] m_valM_o,
    output logic [2:0]  m_stat_o,
    output logic        m_busy_o
);

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd3;

    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam int          CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [63:0]        r_addr;
    logic [63:0]        r_wdata;
    logic               r_we;
    logic [63:0]        r_data;
    logic               r_err;

    logic               w_is_read;
    logic               w_is_write;
    logic               w_is_mem;
    logic               w_stack_addr;
    logic [63:0]        w_addr;
    logic               w_legal;
    logic               w_need;
    logic               w_bad_addr;
    logic               w_ack_hit;
    logic               w_timeout;

    // Instruction decode and address legality for the instruction sitting in M
    always_comb begin
        w_is_read    = (M_icode_i == IMRMOVQ) || (M_icode_i == IPOPQ) || (M_icode_i == IRET);
        w_is_write   = (M_icode_i == IRMMOVQ) || (M_icode_i == IPUSHQ) || (M_icode_i == ICALL);
        w_is_mem     = w_is_read || w_is_write;
        w_stack_addr = (M_icode_i == IPOPQ) || (M_icode_i == IRET);
        w_addr       = w_stack_addr ? M_valA_i : M_valE_i;
        w_legal      = (w_addr <= MAX_ADDR);
        w_need       = w_is_mem && (M_stat_i == SAOK) && w_legal;
        w_bad_addr   = w_is_mem && (M_stat_i == SAOK) && !w_legal;
    end

    assign w_ack_hit = (r_state == S_REQ) && dmem_ack_i;
    assign w_timeout = (r_state == S_REQ) && !dmem_ack_i && (r_cnt == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        m_busy_o    = 1'b0;
        m_valM_o    = 64'd0;
        m_stat_o    = M_stat_i;
        case (r_state)
            S_IDLE: begin
                if (w_need) begin
                    w_state_nxt = S_REQ;
                    m_busy_o    = 1'b1;
                end else if (w_bad_addr) begin
                    m_stat_o = SADR;
                end
            end
            S_REQ: begin
                m_busy_o = 1'b1;
                m_stat_o = SAOK;
                if (w_ack_hit || w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                m_valM_o = r_data;
                m_stat_o = r_err ? SADR : SAOK;
                if (!W_stall_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request is frozen on entry to REQ so the bus never sees addr/data move mid-transaction
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt   <= '0;
            r_addr  <= 64'd0;
            r_wdata <= 64'd0;
            r_we    <= 1'b0;
            r_data  <= 64'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_need) begin
                        r_cnt   <= '0;
                        r_addr  <= w_addr;
                        r_wdata <= M_valA_i;
                        r_we    <= w_is_write;
                        r_data  <= 64'd0;
                        r_err   <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (w_ack_hit) begin
                        r_data <= r_we ? 64'd0 : dmem_rdata_i;
                        r_err  <= dmem_err_i;
                    end else if (w_timeout) begin
                        r_data <= 64'd0;
                        r_err  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        dmem_req_o   = (r_state == S_REQ);
        dmem_we_o    = dmem_req_o ? r_we    : 1'b0;
        dmem_addr_o  = dmem_req_o ? r_addr  : 64'd0;
        dmem_wdata_o = dmem_req_o ? r_wdata : 64'd0;
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: scoreboard of expected (valM, stat) results
// pushed when an instruction enters M and popped when the stage delivers it.
module tb_memory_stage;

    localparam int MEM_BYTES = 65536;
    localparam int TIMEOUT   = 16;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic        W_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        dmem_err;
    logic [63:0] m_valM;
    logic [2:0]  m_stat;
    logic        m_busy;

    int checks   = 0;
    int failures = 0;
    logic [66:0] sb_q[$];

    always #5 clk = ~clk;

    memory_stage #(.MEM_BYTES(MEM_BYTES), .TIMEOUT(TIMEOUT)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .M_stat_i     (M_stat),
        .M_icode_i    (M_icode),
        .M_valE_i     (M_valE),
        .M_valA_i     (M_valA),
        .W_stall_i    (W_stall),
        .dmem_req_o   (dmem_req),
        .dmem_we_o    (dmem_we),
        .dmem_addr_o  (dmem_addr),
        .dmem_wdata_o (dmem_wdata),
        .dmem_ack_i   (dmem_ack),
        .dmem_rdata_i (dmem_rdata),
        .dmem_err_i   (dmem_err),
        .m_valM_o     (m_valM),
        .m_stat_o     (m_stat),
        .m_busy_o     (m_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] st, input logic [3:0] ic,
                         input logic [63:0] ve, input logic [63:0] va);
        M_stat  = st;
        M_icode = ic;
        M_valE  = ve;
        M_valA  = va;
    endtask

    task automatic pop_check(input string tag);
        logic [66:0] e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_valM"}, m_valM, e[66:3]);
            chk({tag, "_stat"}, {61'd0, m_stat}, {61'd0, e[2:0]});
        end
    endtask

    // Instructions resolved combinationally in their arrival cycle
    task automatic comb_op(input string tag, input logic [2:0] st, input logic [3:0] ic,
                           input logic [63:0] ve, input logic [2:0] exp_stat);
        drive(st, ic, ve, 64'h0);
        sb_q.push_back({64'd0, exp_stat});
        #1;
        pop_check(tag);
        chk({tag, "_busy"}, {63'd0, m_busy}, 64'd0);
        chk({tag, "_req"}, {63'd0, dmem_req}, 64'd0);
        tick();
        chk({tag, "_req_next"}, {63'd0, dmem_req}, 64'd0);
    endtask

    // ack_at = REQ cycle (1-based) that carries the ack; 0 means never acknowledge
    task automatic mem_op(input string tag, input logic [3:0] ic,
                          input logic [63:0] ve, input logic [63:0] va,
                          input int ack_at, input logic [63:0] rdata, input logic err,
                          input int exp_req, input int stall_cycles);
        logic [63:0] exp_addr;
        logic        exp_we;
        logic [63:0] held_valM;
        logic [2:0]  held_stat;
        int          nreq;
        int          nbusy;
        exp_addr = (ic == IPOPQ || ic == IRET) ? va : ve;
        exp_we   = (ic == IRMMOVQ || ic == IPUSHQ || ic == ICALL);
        if (ack_at == 0)
            sb_q.push_back({64'd0, SADR});
        else
            sb_q.push_back({(exp_we ? 64'd0 : rdata), (err ? SADR : SAOK)});
        drive(SAOK, ic, ve, va);
        #1;
        chk({tag, "_arr_busy"}, {63'd0, m_busy}, 64'd1);
        chk({tag, "_arr_req"}, {63'd0, dmem_req}, 64'd0);
        nbusy = 1;
        nreq  = 0;
        tick();
        for (int i = 1; i <= 40 && dmem_req === 1'b1; i++) begin
            nreq++;
            if (m_busy === 1'b1) nbusy++;
            chk({tag, "_addr"}, dmem_addr, exp_addr);
            chk({tag, "_we"}, {63'd0, dmem_we}, {63'd0, exp_we});
            if (exp_we) chk({tag, "_wdata"}, dmem_wdata, va);
            if (i == ack_at) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
                dmem_err   = err;
            end
            tick();
            dmem_ack   = 1'b0;
            dmem_rdata = 64'h0;
            dmem_err   = 1'b0;
        end
        chk({tag, "_req_cycles"}, 64'(nreq), 64'(exp_req));
        chk({tag, "_busy_cycles"}, 64'(nbusy), 64'(exp_req + 1));
        chk({tag, "_done_busy"}, {63'd0, m_busy}, 64'd0);
        pop_check(tag);
        if (stall_cycles > 0) begin
            held_valM = m_valM;
            held_stat = m_stat;
            W_stall   = 1'b1;
            repeat (stall_cycles) begin
                tick();
                chk({tag, "_stall_req"}, {63'd0, dmem_req}, 64'd0);
                chk({tag, "_stall_busy"}, {63'd0, m_busy}, 64'd0);
                chk({tag, "_stall_valM"}, m_valM, held_valM);
                chk({tag, "_stall_stat"}, {61'd0, m_stat}, {61'd0, held_stat});
            end
            W_stall = 1'b0;
        end
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        W_stall    = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 64'h0;
        dmem_err   = 1'b0;
        drive(SAOK, INOP, 64'h0, 64'h0);
        repeat (2) tick();
        chk("rst_req", {63'd0, dmem_req}, 64'd0);
        chk("rst_busy", {63'd0, m_busy}, 64'd0);
        chk("rst_valM", m_valM, 64'd0);
        chk("rst_addr", dmem_addr, 64'd0);
        chk("rst_stat", {61'd0, m_stat}, {61'd0, SAOK});
        rst_n = 1'b1;
        tick();

        mem_op("mrmovq", IMRMOVQ, 64'h100, 64'h0, 2, 64'hDEADBEEF, 1'b0, 2, 0);
        mem_op("pushq", IPUSHQ, 64'h1F8, 64'h55, 1, 64'h0, 1'b0, 1, 0);
        mem_op("rmmovq_edge", IRMMOVQ, 64'(MEM_BYTES - 8), 64'hA5A5, 1, 64'h0, 1'b0, 1, 0);
        comb_op("bad_addr", SAOK, IMRMOVQ, 64'(MEM_BYTES - 7), SADR);
        comb_op("sins", SINS, IMRMOVQ, 64'h100, SINS);
        mem_op("timeout", IMRMOVQ, 64'h80, 64'h0, 0, 64'h0, 1'b0, TIMEOUT, 0);
        mem_op("popq_err", IPOPQ, 64'h208, 64'h200, 1, 64'h0, 1'b1, 1, 0);
        mem_op("ret", IRET, 64'h18, 64'h10, 1, 64'h4242, 1'b0, 1, 0);
        mem_op("call", ICALL, 64'h300, 64'h77, 2, 64'h0, 1'b0, 2, 0);
        mem_op("stall", IMRMOVQ, 64'h40, 64'h0, 3, 64'h0123456789ABCDEF, 1'b0, 3, 3);
        comb_op("irmovq", SAOK, IIRMOVQ, 64'h1234, SAOK);
        comb_op("nop", SAOK, INOP, 64'h0, SAOK);

        // A stray ack while idle must not disturb the stage
        drive(SAOK, INOP, 64'h0, 64'h0);
        dmem_ack   = 1'b1;
        dmem_err   = 1'b1;
        dmem_rdata = 64'hBAD;
        tick();
        dmem_ack   = 1'b0;
        dmem_err   = 1'b0;
        dmem_rdata = 64'h0;
        chk("stray_ack_stat", {61'd0, m_stat}, {61'd0, SAOK});
        chk("stray_ack_valM", m_valM, 64'd0);
        chk("stray_ack_busy", {63'd0, m_busy}, 64'd0);

        // Reset while a request is outstanding
        drive(SAOK, IMRMOVQ, 64'h500, 64'h0);
        tick();
        chk("rst_mid_req_before", {63'd0, dmem_req}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req_after", {63'd0, dmem_req}, 64'd0);
        chk("rst_mid_valM", m_valM, 64'd0);
        chk("rst_mid_addr", dmem_addr, 64'd0);
        drive(SAOK, INOP, 64'h0, 64'h0);
        #1;
        chk("rst_mid_busy", {63'd0, m_busy}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_req", {63'd0, dmem_req}, 64'd0);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
